mips_mem_responder: RTL and testbench

- Memory-side responder for the pipelined MIPS core: serves the core's instruction-fetch port and data load/store port from one unified word array.
- Owns program bring-up:
  - zero-fills the array;
  - accepts a program image from a host over a valid/ready stream;
  - holds the core in reset until loading finishes.
- Sits between testbench/host and the processor, one level above it in the SoC top.

---
 rtl/mips_mem_pkg.sv | 24 ++
 rtl/mem_array_1w2r.sv | 28 ++
 rtl/mips_mem_responder.sv | 151 +++++++++++++++
 tb/tb_mips_mem_responder.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS memory responder.
// Covers the FSM encoding, the NOP word and the address decode helpers.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_LOAD  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    localparam logic [31:0] NOP = 32'h0;

    // True when the byte address falls inside a 2**addr_w word array.
    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned addr_w);
        return (addr >> (addr_w + 2)) == 32'd0;
    endfunction

    // Word index of a byte address; the caller narrows it to its own width.
    function automatic logic [31:0] word_index(input logic [31:0] addr);
        return addr >> 2;
    endfunction

endpackage

// File: rtl/mem_array_1w2r.sv
// 32-bit word array: one synchronous write port, two asynchronous read ports.
// Contents are deliberately not reset; the owner zero-fills it.
module mem_array_1w2r #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [31:0]       i_wdata,
    input  logic [ADDR_W-1:0] i_raddr_a,
    output logic [31:0]       o_rdata_a,
    input  logic [ADDR_W-1:0] i_raddr_b,
    output logic [31:0]       o_rdata_b
);

    logic [31:0] r_mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Reads see the pre-write contents during a same-cycle write.
    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/mips_mem_responder.sv
// Memory-side responder for the pipelined MIPS core: zero-fills the array,
// loads the host image, holds the core in reset, then serves fetch and load/store.
module mips_mem_responder
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int RST_HOLD = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_out,
    input  logic        data_wr,
    output logic [31:0] data_in,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [31:0] load_data,
    input  logic        load_last,
    output logic        cpu_rst_n,
    output logic        busy,
    output logic        err_oob,
    output logic        err_misalign,
    output logic        load_overflow,
    output logic [1:0]  dbg_state
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W:0] CNT_LAST_WORD = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] CNT_LAST_HOLD = (ADDR_W+1)'(RST_HOLD - 1);

    state_t            r_state, w_state_nxt;
    logic [ADDR_W:0]   r_cnt, w_cnt_nxt;
    logic              r_load_ready, r_cpu_rst_n;
    logic              r_err_oob, r_err_misalign, r_load_overflow;
    logic              w_set_ovf;

    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [31:0]       w_wdata;
    logic [ADDR_W-1:0] w_inst_idx, w_data_idx;
    logic              w_inst_in_range, w_data_in_range;
    logic [31:0]       w_rdata_inst, w_rdata_data;

    assign w_inst_idx      = ADDR_W'(word_index(inst_addr));
    assign w_data_idx      = ADDR_W'(word_index(data_addr));
    assign w_inst_in_range = addr_in_range(inst_addr, ADDR_W);
    assign w_data_in_range = addr_in_range(data_addr, ADDR_W);

    // Next state, counter and the state-muxed write port (CLEAR zero / LOAD host / RUN core).
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_set_ovf   = 1'b0;
        w_we        = 1'b0;
        w_waddr     = r_cnt[ADDR_W-1:0];
        w_wdata     = NOP;
        case (r_state)
            ST_CLEAR: begin
                w_we = 1'b1;
                if (r_cnt == CNT_LAST_WORD) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_LOAD;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_LOAD: begin
                if (load_valid && r_load_ready) begin
                    w_we    = 1'b1;
                    w_wdata = load_data;
                    if (load_last) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_HOLD;
                    end else if (r_cnt == CNT_LAST_WORD) begin
                        w_set_ovf   = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_HOLD;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (r_cnt == CNT_LAST_HOLD) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_RUN;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_RUN: begin
                w_we    = data_wr && w_data_in_range;
                w_waddr = w_data_idx;
                w_wdata = data_out;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_CLEAR;
            r_cnt           <= '0;
            r_load_ready    <= 1'b0;
            r_cpu_rst_n     <= 1'b0;
            r_err_oob       <= 1'b0;
            r_err_misalign  <= 1'b0;
            r_load_overflow <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_cnt           <= w_cnt_nxt;
            r_load_ready    <= (w_state_nxt == ST_LOAD);
            r_cpu_rst_n     <= (w_state_nxt == ST_RUN);
            r_load_overflow <= r_load_overflow | w_set_ovf;
            // Fetch port is an access every cycle; the data port only when storing.
            if (r_state == ST_RUN) begin
                if (!w_inst_in_range)          r_err_oob      <= 1'b1;
                if (inst_addr[1:0] != 2'b00)   r_err_misalign <= 1'b1;
                if (data_wr) begin
                    if (!w_data_in_range)        r_err_oob      <= 1'b1;
                    if (data_addr[1:0] != 2'b00) r_err_misalign <= 1'b1;
                end
            end
        end
    end

    mem_array_1w2r #(.ADDR_W(ADDR_W)) u_array (
        .clk       (clk),
        .i_we      (w_we),
        .i_waddr   (w_waddr),
        .i_wdata   (w_wdata),
        .i_raddr_a (w_inst_idx),
        .o_rdata_a (w_rdata_inst),
        .i_raddr_b (w_data_idx),
        .o_rdata_b (w_rdata_data)
    );

    assign inst    = (r_state == ST_RUN && w_inst_in_range) ? w_rdata_inst : NOP;
    assign data_in = (r_state == ST_RUN && w_data_in_range) ? w_rdata_data : NOP;

    assign load_ready    = r_load_ready;
    assign cpu_rst_n     = r_cpu_rst_n;
    assign busy          = (r_state != ST_RUN);
    assign err_oob       = r_err_oob;
    assign err_misalign  = r_err_misalign;
    assign load_overflow = r_load_overflow;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_mips_mem_responder.sv
// Bench for mips_mem_responder: bring-up timing, image load, core accesses
// against a word-array reference model, error flags, overflow and mid-run reset.
module tb_mips_mem_responder;

    localparam int ADDR_W   = 10;
    localparam int DEPTH    = 1 << ADDR_W;
    localparam int RST_HOLD = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] inst_addr = '0, data_addr = '0, data_out = '0, load_data = '0;
    logic        data_wr = 1'b0, load_valid = 1'b0, load_last = 1'b0;
    logic [31:0] inst, data_in;
    logic        load_ready, cpu_rst_n, busy, err_oob, err_misalign, load_overflow;
    logic [1:0]  dbg_state;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] model_mem [DEPTH];
    logic [31:0] exp_q [$];
    logic        exp_oob = 1'b0;
    logic        exp_mis = 1'b0;

    // ---------------- clock / DUT ----------------
    always #5 clk = ~clk;

    mips_mem_responder #(.ADDR_W(ADDR_W), .RST_HOLD(RST_HOLD)) dut (
        .clk(clk), .rst_n(rst_n),
        .inst_addr(inst_addr), .inst(inst),
        .data_addr(data_addr), .data_out(data_out), .data_wr(data_wr), .data_in(data_in),
        .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data), .load_last(load_last),
        .cpu_rst_n(cpu_rst_n), .busy(busy),
        .err_oob(err_oob), .err_misalign(err_misalign), .load_overflow(load_overflow),
        .dbg_state(dbg_state)
    );

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        if (addr < 32'(DEPTH * 4)) return model_mem[int'(addr >> 2)];
        return 32'h0;
    endfunction

    // ---------------- driver tasks ----------------
    // Called at #1 after a rising edge; returns at #1 after the next one.
    task automatic core_cycle(input string tag, input logic [31:0] ia, input logic [31:0] da,
                              input logic wr, input logic [31:0] wd);
        inst_addr = ia; data_addr = da; data_wr = wr; data_out = wd;
        exp_q.push_back(model_read(ia));
        exp_q.push_back(model_read(da));
        @(negedge clk);
        check({tag, ".inst"}, inst, exp_q.pop_front());
        check({tag, ".data_in"}, data_in, exp_q.pop_front());
        check({tag, ".ready"}, load_ready, 1'b0);
        if (ia >= 32'(DEPTH * 4) || ia[1:0] != 2'b00) begin
            if (ia >= 32'(DEPTH * 4)) exp_oob = 1'b1;
            if (ia[1:0] != 2'b00)     exp_mis = 1'b1;
        end
        if (wr) begin
            if (da >= 32'(DEPTH * 4)) exp_oob = 1'b1;
            else                      model_mem[int'(da >> 2)] = wd;
            if (da[1:0] != 2'b00)     exp_mis = 1'b1;
        end
        @(posedge clk);
        #1;
        data_wr = 1'b0;
        check({tag, ".err_oob"}, err_oob, exp_oob);
        check({tag, ".err_mis"}, err_misalign, exp_mis);
    endtask

    // Counts cycles from reset release until load_ready rises; returns at that cycle's negedge.
    task automatic wait_clear(input string tag);
        int rise = 0;
        logic bad = 1'b0;
        for (int i = 1; i <= DEPTH + 8; i++) begin
            inst_addr = 32'($urandom_range(0, DEPTH - 1)) << 2;
            @(negedge clk);
            if (load_ready === 1'b1) begin
                rise = i;
                break;
            end
            if (inst !== 32'h0 || data_in !== 32'h0 || cpu_rst_n !== 1'b0 || busy !== 1'b1) bad = 1'b1;
            @(posedge clk);
            #1;
        end
        check({tag, ".ready_cycle"}, rise, DEPTH + 1);
        check({tag, ".outputs_quiet"}, bad, 1'b0);
        check({tag, ".state_load"}, dbg_state, 2'd1);
        check({tag, ".inst_nop"}, inst, 32'h0);
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] image [3];
        int beats;
        int n;
        int acc;
        image[0] = 32'h2001_0005;
        image[1] = 32'h2002_0007;
        image[2] = 32'h0022_1820;

        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.cpu_rst_n", cpu_rst_n, 1'b0);
        check("rst.load_ready", load_ready, 1'b0);
        check("rst.busy", busy, 1'b1);
        check("rst.flags", {err_oob, err_misalign, load_overflow}, 3'b000);
        check("rst.state", dbg_state, 2'd0);
        check("rst.inst", inst, 32'h0);

        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_clear("clear1");

        // Three-word image, valid on every other cycle.
        beats = 0;
        for (int w = 0; w < 3; w++) begin
            @(posedge clk); #1 load_valid = 1'b0;
            @(posedge clk); #1 load_valid = 1'b1; load_data = image[w]; load_last = (w == 2);
            @(negedge clk);
            if (load_ready === 1'b1) begin
                beats++;
                model_mem[w] = image[w];
            end
        end
        @(posedge clk); #1 load_valid = 1'b0; load_last = 1'b0;
        check("load.beats", beats, 3);
        @(negedge clk);
        check("load.ready_drop", load_ready, 1'b0);
        check("load.hold_cpu_rst", cpu_rst_n, 1'b0);
        n = 1;
        while (cpu_rst_n !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("load.release_cycle", n, RST_HOLD + 1);
        check("run.busy", busy, 1'b0);
        check("run.state", dbg_state, 2'd3);

        core_cycle("img8", 32'h8, 32'hC, 1'b0, 32'h0);
        core_cycle("img0", 32'h0, 32'h4, 1'b0, 32'h0);

        // Same-word fetch and store: old value now, new value next cycle.
        core_cycle("st10", 32'h10, 32'h10, 1'b1, 32'hDEAD_BEEF);
        core_cycle("rd10", 32'h10, 32'h10, 1'b0, 32'h0);
        check("rd10.const", model_read(32'h10), 32'hDEAD_BEEF);

        // Out-of-range store is dropped (would alias word 0 if truncated).
        core_cycle("oob_st", 32'h0, 32'h0001_0000, 1'b1, 32'h1234_5678);
        core_cycle("oob_ld", 32'h0, 32'h0001_0000, 1'b0, 32'h0);
        check("oob.flag", err_oob, 1'b1);

        core_cycle("mis_st", 32'h4, 32'h13, 1'b1, 32'hCAFE_F00D);
        core_cycle("mis_ld", 32'h10, 32'h10, 1'b0, 32'h0);
        check("mis.flag", err_misalign, 1'b1);

        // Random core traffic; host beats during RUN must be ignored.
        for (int i = 0; i < 300; i++) begin
            logic [31:0] ia, da;
            ia = ($urandom_range(0, 15) == 0) ? $urandom : (32'($urandom_range(0, DEPTH - 1)) << 2);
            da = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, DEPTH * 4 - 1));
            load_valid = $urandom_range(0, 1) == 1;
            load_data  = $urandom;
            core_cycle("rand", ia, da, $urandom_range(0, 1) == 1, $urandom);
        end
        load_valid = 1'b0;

        // Reset clears everything and restarts CLEAR.
        @(posedge clk); #1 rst_n = 1'b0;
        #2;
        check("rst2.flags", {err_oob, err_misalign, load_overflow}, 3'b000);
        check("rst2.cpu_rst_n", cpu_rst_n, 1'b0);
        check("rst2.state", dbg_state, 2'd0);
        exp_oob = 1'b0; exp_mis = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        wait_clear("clear2");

        // Overflow: DEPTH+2 beats with no last marker.
        acc = 0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            @(posedge clk); #1 load_valid = 1'b1; load_data = $urandom; load_last = 1'b0;
            @(negedge clk);
            if (load_ready === 1'b1) acc++;
        end
        @(posedge clk); #1 load_valid = 1'b0;
        check("ovf.accepted", acc, DEPTH);
        check("ovf.flag", load_overflow, 1'b1);
        check("ovf.ready", load_ready, 1'b0);
        check("ovf.state_hold", dbg_state, 2'd2);
        check("ovf.cpu_rst_n", cpu_rst_n, 1'b0);

        // Asynchronous reset in the middle of HOLD.
        #2 rst_n = 1'b0;
        #1;
        check("hold_rst.state", dbg_state, 2'd0);
        check("hold_rst.ovf", load_overflow, 1'b0);
        check("hold_rst.cpu_rst_n", cpu_rst_n, 1'b0);
        check("hold_rst.ready", load_ready, 1'b0);
        check("hold_rst.busy", busy, 1'b1);
        @(posedge clk); #1 rst_n = 1'b1;
        wait_clear("clear3");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
